// File: rtl/halfwave_pwm.sv
// Half-wave magnitude pair to complementary H-bridge PWM with dead time on polarity reversal.
// One sample pair is latched per 256-cycle period; sample_req asks the source for the next pair.
`timescale 1ns/1ps
module halfwave_pwm #(
  parameter int DEAD_CYCLES = 4  // legal range 0..64, so DEAD always ends before the next latch edge
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pos_in,
  input  logic [7:0] neg_in,
  output logic       sample_req,
  output logic       drive_p,
  output logic       drive_n,
  output logic       fault
);

  typedef enum logic [1:0] {ST_IDLE, ST_POS, ST_NEG, ST_DEAD} state_t;

  localparam logic [6:0] DEAD_LOAD = (DEAD_CYCLES > 0) ? 7'(DEAD_CYCLES - 1) : 7'd0;

  logic [7:0] r_cnt;
  logic [7:0] r_duty;
  logic [6:0] r_dead_cnt;
  logic       r_sample_req;
  logic       r_fault;
  state_t     r_state;
  state_t     r_target;

  logic       w_latch;
  logic       w_both;
  logic       w_reversal;
  state_t     w_cls;
  logic [7:0] w_cls_duty;
  state_t     w_next_state;
  state_t     w_next_target;
  logic [6:0] w_next_dead_cnt;

  assign w_latch = (r_cnt == 8'hFF);
  assign w_both  = (pos_in != 8'd0) && (neg_in != 8'd0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_cls      = ST_IDLE;
    w_cls_duty = 8'd0;
    if (pos_in != 8'd0 && neg_in == 8'd0) begin
      w_cls      = ST_POS;
      w_cls_duty = pos_in;
    end else if (neg_in != 8'd0 && pos_in == 8'd0) begin
      w_cls      = ST_NEG;
      w_cls_duty = neg_in;
    end
  end

  assign w_reversal = ((r_state == ST_POS) && (w_cls == ST_NEG)) ||
                      ((r_state == ST_NEG) && (w_cls == ST_POS));

  always_comb begin
    w_next_state    = r_state;
    w_next_target   = r_target;
    w_next_dead_cnt = r_dead_cnt;
    if (r_state == ST_DEAD) begin
      if (r_dead_cnt == 7'd0) begin
        w_next_state = r_target;
      end else begin
        w_next_dead_cnt = r_dead_cnt - 7'd1;
      end
    end else if (w_latch) begin
      if (w_reversal && (DEAD_CYCLES > 0)) begin
        w_next_state    = ST_DEAD;
        w_next_target   = w_cls;
        w_next_dead_cnt = DEAD_LOAD;
      end else begin
        w_next_state = w_cls;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= 8'd0;
      r_duty       <= 8'd0;
      r_dead_cnt   <= 7'd0;
      r_sample_req <= 1'b0;
      r_fault      <= 1'b0;
      r_state      <= ST_IDLE;
      r_target     <= ST_IDLE;
    end else begin
      r_cnt        <= r_cnt + 8'd1;
      r_sample_req <= w_latch;
      r_state      <= w_next_state;
      r_target     <= w_next_target;
      r_dead_cnt   <= w_next_dead_cnt;
      if (w_latch) begin
        r_duty <= w_cls_duty;
        if (w_both) r_fault <= 1'b1;
      end
    end
  end

  // Outputs decode flops only, so an asserted reset drops both legs without waiting for a clock.
  assign drive_p    = (r_state == ST_POS) && (r_cnt < r_duty);
  assign drive_n    = (r_state == ST_NEG) && (r_cnt < r_duty);
  assign sample_req = r_sample_req;
  assign fault      = r_fault;

endmodule

// File: doc/halfwave_pwm.md
# halfwave_pwm

Converts the two 8-bit half-wave magnitude streams of the sine generator into complementary PWM drive for an H-bridge speaker stage. One sample pair is latched per PWM period, and the block requests the next sample with a one-cycle pulse; that pulse is the sample clock/enable for the generator. Switching polarity inserts a programmable dead time so both bridge legs are never driven together. Simultaneous nonzero inputs raise a sticky fault.

## Interface
- DEAD_CYCLES, 4, dead-time length in clk cycles on a POS↔NEG reversal; legal 0..64
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (low = reset asserted)
- pos_in  in  8  positive half-wave magnitude (0 = none)
- neg_in  in  8  negative half-wave magnitude (0 = none)
- sample_req  out  1  one-cycle pulse; the source advances to the next sample
- drive_p  out  1  positive bridge leg PWM
- drive_n  out  1  negative bridge leg PWM
- fault  out  1  sticky; both inputs were nonzero at a latch edge

## Operation
- cnt: 8-bit free-running period counter, 0..255, wraps 255→0; period = 256 cycles.
- Latch edge: the clk edge where cnt goes 255→0. On it:
  - duty_r ← classified magnitude.
  - The state machine takes its period-boundary transition.
- Classification of (pos_in, neg_in) at the latch edge:
  - pos≠0, neg=0 → target POS, duty pos_in.
  - neg≠0, pos=0 → target NEG, duty neg_in.
  - Both 0 → target IDLE, duty 0.
  - Both ≠0 → fault←1, target IDLE, duty 0.
- States: IDLE, POS, NEG, DEAD. Transitions occur only at the latch edge, except leaving DEAD.
  - IDLE→POS/NEG directly; POS/NEG→IDLE directly.
  - POS→POS and NEG→NEG: stay, new duty.
  - POS→NEG or NEG→POS with DEAD_CYCLES>0: go to DEAD, load dead_cnt=DEAD_CYCLES-1, store target.
  - Same reversal with DEAD_CYCLES=0: go directly to the target.
  - DEAD: dead_cnt decrements each cycle; at dead_cnt=0, go to the stored target on the next edge.
  - DEAD_CYCLES≤64, so DEAD always ends before the next latch edge.
- Outputs are combinational from flops only:
  - drive_p = (state==POS) && (cnt < duty_r).
  - drive_n = (state==NEG) && (cnt < duty_r).
  - drive_p and drive_n are never both 1.
- Duty arithmetic is an 8-bit unsigned compare. High time per period:
  - duty cycles normally; duty 255 gives 255 high, 1 low.
  - After a reversal: max(0, duty − DEAD_CYCLES), because cnt keeps running during DEAD.
- sample_req: registered; high exactly in the cycle where cnt==0, one pulse per 256 cycles.
- fault: sets on a both-nonzero latch edge. Only reset clears it. Operation continues normally on later clean samples.

## Timing
- Reset (async, while low):
  - cnt=0, state=IDLE, duty_r=0, dead_cnt=0.
  - sample_req=0, drive_p=0, drive_n=0, fault=0.
  - Drives drop immediately, including mid-period.
- After reset release:
  - The first latch edge is the 256th rising edge.
  - The first sample_req is high in the following cycle (cnt==0).
- Latency: input value at latch edge → drive effect in the immediately following period (cnt 0 onward).
- Inputs need to be stable only around the latch edge. Source update on sample_req gives 255 cycles of setup before the next latch.
- Dead time: both drives low for cnt 0..DEAD_CYCLES−1 of the reversal period. The target leg may go high from cnt==DEAD_CYCLES.

## Test plan
- Reset values: hold reset low, pulse clk.
  - Required: all outputs 0.
  - Then assert reset low mid-period with drive_p high → drive_p=0 with no clk edge.
- Steady positive: pos_in=128, neg_in=0.
  - Required: drive_p high for cnt 0..127 and low for 128..255 every period.
  - drive_n always 0; sample_req pulses exactly 256 cycles apart.
- Reversal: one period POS duty 200, then pos_in=0, neg_in=100, DEAD_CYCLES=4.
  - Required: in the reversal period drive_p=0, drive_n low for cnt 0..3 and high for cnt 4..99 (96 cycles).
  - The next period (neg 100) gives 100 high cycles.
- Duty extremes: duty 0, duty 3 after a reversal, duty 255 steady.
  - Required respectively: no high cycles; 0 high cycles; 255 high / 1 low per period.
- Fault: pos_in=50, neg_in=60 at a latch edge.
  - Required: fault=1 from that edge and both drives low that period.
  - Then pos_in=50, neg_in=0 → drive_p 50 cycles, fault stays 1 until reset.
- System: sine generator clocked by sample_req, run 256 samples.
  - Required: 128 periods with drive_p only, then 128 with drive_n only.
  - The duty sequence equals the LUT values, and no cycle has drive_p and drive_n both high.
